// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encodings, frame constants and the length-field check.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_SUM  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int LEN_BYTES = 2;
  localparam int SUM_WIDTH = 8;

  // A frame may hold 1 .. 2**aw words; anything else is rejected.
  function automatic logic len_ok(input logic [15:0] n, input int aw);
    return (n != 16'd0) && (32'(n) <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = byte source / observer, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  reload;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  imem_we;
  logic                  core_rst;
  logic                  done;
  logic                  err;

  modport master (
    output rx_valid, rx_data, reload,
    input  imem_addr, imem_wdata, imem_we, core_rst, done, err
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output imem_addr, imem_wdata, imem_we, core_rst, done, err
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; emits a one-cycle
// word_valid together with the completed word.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= 2'd0;
      shift      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
      end else if (en) begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          word       <= {byte_in, shift};
          word_valid <= 1'b1;
        end else begin
          shift <= {byte_in, shift[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/payload/SUM frames from the UART byte stream,
// writes words into imem from address 0 and releases the core on a good frame.
//
// state  | meaning
// S_LEN0 | wait for LEN_LO
// S_LEN1 | wait for LEN_HI, validate N
// S_DATA | collect 4*N payload bytes
// S_SUM  | compare checksum byte
// S_RUN  | core running
// S_ERR  | frame rejected
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 1000000
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [7:0]            len_lo;
  logic [15:0]           len_n;
  logic [ADDR_WIDTH-1:0] n_last;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SUM_WIDTH-1:0]  sum;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic                  timed;
  logic                  timeout;
  logic                  clr;
  logic                  core_rst_q, done_q, err_q;
  logic [1:0]            lane;
  logic                  word_valid;
  logic [31:0]           word;

  assign accept  = bus.rx_valid & ~bus.reload;
  assign len_n   = {bus.rx_data, len_lo};
  assign timed   = state inside {S_LEN1, S_DATA, S_SUM};
  assign timeout = timed & ~accept & (timer == '0);
  assign clr     = (state_nxt == S_LEN0);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (accept && (state == S_DATA)),
    .byte_in    (bus.rx_data),
    .lane       (lane),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.reload || timeout) begin
      state_nxt = S_LEN0;
    end else if (accept) begin
      case (state)
        S_LEN0: state_nxt = S_LEN1;
        S_LEN1: state_nxt = len_ok(len_n, ADDR_WIDTH) ? S_DATA : S_ERR;
        S_DATA: if (lane == 2'd3 && word_cnt == n_last) state_nxt = S_SUM;
        S_SUM:  state_nxt = (bus.rx_data == sum) ? S_RUN : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo   <= 8'd0;
      n_last   <= '0;
      word_cnt <= '0;
      sum      <= '0;
      timer    <= '0;
    end else begin
      if (accept)                      timer <= TW'(TIMEOUT - 1);
      else if (timed && timer != '0)   timer <= timer - TW'(1);

      if (clr) begin
        word_cnt <= '0;
        sum      <= '0;
      end else if (accept && state == S_DATA) begin
        sum <= sum + bus.rx_data;
        if (lane == 2'd3) word_cnt <= word_cnt + ADDR_WIDTH'(1);
      end

      if (accept && state == S_LEN0) len_lo <= bus.rx_data;
      if (accept && state == S_LEN1) n_last <= ADDR_WIDTH'(len_n - 16'd1);
    end
  end

  // The address only advances while more words follow, so it parks on the
  // last written word and never wraps for a full-capacity frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      core_rst_q <= (state_nxt != S_RUN);
      done_q     <= (state_nxt == S_RUN);
      err_q      <= (state_nxt == S_ERR);
      if (clr)                                addr_q <= '0;
      else if (word_valid && state == S_DATA) addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign bus.imem_we    = word_valid;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from random words, the
// expected imem writes are queued at issue time and checked by a monitor.
module tb_imem_loader;

  localparam int AW = 12;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h expected=no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), e.addr);
        chk("write_data", bus.imem_wdata, e.data);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("reload_core_rst", bus.core_rst, 1);
    chk("reload_done", bus.done, 0);
  endtask

  task automatic chk_status(input string tag, input bit d, input bit e);
    chk({tag, "_done"}, bus.done, d);
    chk({tag, "_err"}, bus.err, e);
    chk({tag, "_core_rst"}, bus.core_rst, !d);
  endtask

  task automatic chk_reset_values();
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_we", bus.imem_we, 0);
    chk_status("rst", 1'b0, 1'b0);
  endtask

  // abort_bytes < 0 sends a whole frame; otherwise that many payload bytes, then reload.
  task automatic send_frame(input int n, input bit bad_sum, input int max_gap, input int abort_bytes);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] n16;
    int          nbytes;
    sum = 8'd0;
    n16 = 16'(n);
    nbytes = (abort_bytes >= 0) ? abort_bytes : 4 * n;
    send_byte(n16[7:0]);
    idle($urandom_range(max_gap, 0));
    send_byte(n16[15:8]);
    for (int i = 0; i < n && 4 * i < nbytes; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        if (4 * i + b < nbytes) begin
          idle($urandom_range(max_gap, 0));
          if (b == 3) exp_q.push_back('{i, w, cyc + 1});
          send_byte(w[8*b +: 8]);
          sum += w[8*b +: 8];
        end
      end
    end
    idle($urandom_range(max_gap, 0));
    if (abort_bytes >= 0) begin
      pulse_reload();
      chk_status("abort", 1'b0, 1'b0);
    end else begin
      send_byte(bad_sum ? sum + 8'd1 : sum);
      chk_status(bad_sum ? "bad_sum" : "good_sum", !bad_sum, bad_sum);
      if (!bad_sum) chk("final_addr", 32'(bus.imem_addr), n - 1);
    end
  endtask

  initial begin
    logic [7:0] lb;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.reload   = 1'b0;
    idle(3);
    chk_reset_values();
    rst = 1'b0;
    tick();

    // Reference frame from the bring-up notes.
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h01);
    exp_q.push_back('{0, 32'h2001_0005, cyc + 1});
    send_byte(8'h20);
    chk_status("ref_pre_sum", 1'b0, 1'b0);
    send_byte(8'h26);
    chk_status("ref_frame", 1'b1, 1'b0);

    // Bytes while running are ignored.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    chk_status("run_ignore", 1'b1, 1'b0);

    // Reload with a simultaneous byte: the byte must be dropped.
    bus.reload = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h03;
    tick();
    bus.reload = 1'b0; bus.rx_valid = 1'b0;
    chk("reload_rx_core_rst", bus.core_rst, 1);
    chk("reload_rx_done", bus.done, 0);
    send_frame(2, 1'b0, 2, -1);
    pulse_reload();

    // Reference frame with a wrong checksum, then recovery.
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h01);
    exp_q.push_back('{0, 32'h2001_0005, cyc + 1});
    send_byte(8'h20);
    send_byte(8'h27);
    chk_status("ref_bad_sum", 1'b0, 1'b1);
    send_byte(8'h11);
    chk_status("err_ignore", 1'b0, 1'b1);
    pulse_reload();
    send_frame(1, 1'b0, 1, -1);
    pulse_reload();

    // Length boundaries: 0 and 4097 are rejected right after LEN_HI.
    send_byte(8'h00); send_byte(8'h00);
    chk_status("len_zero", 1'b0, 1'b1);
    pulse_reload();
    send_byte(8'h01); send_byte(8'h10);
    chk_status("len_4097", 1'b0, 1'b1);
    pulse_reload();

    // Idle for exactly TIMEOUT cycles mid-frame: resync to a fresh frame.
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    idle(TO);
    chk_status("timeout", 1'b0, 1'b0);
    send_frame(2, 1'b0, 2, -1);
    pulse_reload();

    // Gaps of TIMEOUT-1 cycles must not resync.
    send_byte(8'h01); idle(TO - 1); send_byte(8'h00);
    lb = 8'd0;
    for (int b = 0; b < 4; b++) begin
      idle(TO - 1);
      if (b == 3) exp_q.push_back('{0, 32'h8040_2010, cyc + 1});
      send_byte(8'(8'h10 << b));
      lb += 8'(8'h10 << b);
    end
    idle(TO - 1);
    send_byte(lb);
    chk_status("gap_below_timeout", 1'b1, 1'b0);
    pulse_reload();

    // Randomized frames: good, bad checksum, or aborted part-way.
    for (int it = 0; it < 14; it++) begin
      int n, mode;
      n    = $urandom_range(6, 1);
      mode = $urandom_range(3, 0);
      if (mode == 0)      send_frame(n, 1'b1, $urandom_range(3, 0), -1);
      else if (mode == 1) send_frame(n, 1'b0, $urandom_range(3, 0), $urandom_range(4 * n - 1, 0));
      else                send_frame(n, 1'b0, $urandom_range(3, 0), -1);
      pulse_reload();
    end

    // Full-capacity frame, bytes every cycle.
    send_frame(4096, 1'b0, 0, -1);
    pulse_reload();

    // Synchronous reset in the middle of a frame.
    send_byte(8'h03); send_byte(8'h00);
    exp_q.push_back('{0, 32'h4433_2211, cyc + 4});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    rst = 1'b1;
    tick();
    chk_reset_values();
    rst = 1'b0;
    tick();
    send_frame(1, 1'b0, 1, -1);

    idle(3);
    chk("pending_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the MIPS core's instruction memory. It consumes a byte stream from a UART receiver, checks framing, packs bytes into 32-bit instruction words, and writes them sequentially from address 0. It holds the core in reset until a complete frame with a good checksum has loaded, then releases it.

## Interface
- ADDR_WIDTH, 12, imem word-address width; capacity 2**ADDR_WIDTH words (default 4096).
- TIMEOUT, 1000000, idle cycles allowed between bytes of one frame before resync.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- reload  in  1  one-cycle pulse; abort or leave run and wait for a new frame.
- imem_addr  out  ADDR_WIDTH  word write address.
- imem_wdata  out  32  instruction word.
- imem_we  out  1  write strobe, one cycle per word.
- core_rst  out  1  reset to the processor, active-high.
- done  out  1  frame loaded, core running.
- err  out  1  frame rejected (bad length or checksum).

## Operation
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian), then 4·N payload bytes (each word little-endian, byte 0 = bits 7:0), then SUM. SUM = 8-bit modulo-256 sum of the payload bytes only.
- Valid N is 1..2**ADDR_WIDTH. Any other value goes to S_ERR immediately after LEN_HI.
- States:
  - S_LEN0: wait for LEN_LO.
  - S_LEN1: wait for LEN_HI.
  - S_DATA: collect words.
  - S_SUM: compare checksum.
  - S_RUN: core running.
  - S_ERR: frame rejected.
- Transitions:
  - S_LEN0→S_LEN1 on a byte.
  - S_LEN1→S_DATA if N is valid, else →S_ERR.
  - S_DATA→S_SUM after the 4·N-th payload byte.
  - S_SUM→S_RUN if SUM matches, else →S_ERR.
  - reload in any state→S_LEN0.
  - Idle timeout in S_LEN1, S_DATA or S_SUM→S_LEN0. Counters and the running sum clear.
- On entry to S_LEN0, the word counter, byte-lane counter (2 bits), running sum and imem_addr clear to 0.
- Each completed word produces one imem_we pulse at the current imem_addr. imem_addr then increments; it never wraps inside a valid frame.
- core_rst is 0 only in S_RUN. done = (state==S_RUN). err = (state==S_ERR).
- In S_RUN and S_ERR, rx bytes are ignored. Only reload or rst leaves these states.
- reload and rx_valid in the same cycle: reload wins and the byte is dropped.
- Earlier words stay in imem after an error or abort. They are overwritten by the next frame.

## Timing
- Reset values: imem_addr 0, imem_wdata 0, imem_we 0, core_rst 1, done 0, err 0. State is S_LEN0.
- All outputs are registered.
- imem_we is high exactly in the cycle after the rx_valid that carried byte 3 of a word. imem_addr and imem_wdata are stable in that cycle. imem_addr increments in the following cycle.
- The state changes one cycle after the rx_valid of SUM. core_rst falls and done rises in that same cycle.
- After a reload pulse, core_rst is 1 and done is 0 in the next cycle.
- rx_valid may arrive every cycle. No back-pressure exists.
- Timeout counter: reset on every accepted byte. The state returns to S_LEN0 on the cycle the count reaches TIMEOUT.
- rst mid-frame has the same effect as power-on: the core is held in reset and the partial frame is discarded.

## Structure
- Shared header with the state encodings (S_LEN0..S_ERR, 3-bit) and the frame constants (length field bytes = 2, checksum width = 8). The header is included like the existing instruction-opcode header.
- One sub-module, word_packer: shifts bytes into a 32-bit little-endian word, counts lanes, and emits a one-cycle word_valid with the word.
- The FSM, address/word counters, checksum and timeout counter live in imem_loader.

## Test plan
- Stream 01 00 05 00 01 20 26 → one imem_we at addr 0 with data 0x20010005. Next cycle after 0x26: done=1, core_rst=0, err=0.
- Same frame with SUM=0x27 → err=1, core_rst stays 1, done=0. Then reload followed by the correct frame → done=1.
- Length 00 00, and separately 01 10 (N=4097) → err=1 after LEN_HI, with no imem_we.
- Send LEN and 2 payload bytes, then idle for TIMEOUT cycles → state back to S_LEN0. A following full 2-word frame writes addr 0 and 1 correctly.
- In S_RUN, rx bytes → no imem_we. Then reload together with an rx_valid → byte dropped, core_rst=1 next cycle.
- Back-to-back bytes every cycle for N=4096 → 4096 imem_we pulses, final addr 4095, done=1. rst asserted mid-frame → all outputs at reset values next cycle.
